// File: rtl/iccm_loader.sv
// Boot loader: assembles UART rx bytes into words, writes them to consecutive ICCM addresses, holds the core in reset until an end-of-program word.
// Latency: last byte strobe in cycle n -> we_o in cycle n+1; no backpressure: rx bytes are strobes, one byte accepted per cycle (also during WRITE).
module iccm_loader #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                BIG_ENDIAN  = 1'b1,
  parameter logic [DATA_W-1:0] EOP_WORD    = DATA_W'(32'h0000_0FFF),
  parameter int unsigned       TIMEOUT_CYC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned       BYTES    = DATA_W / 8;
  localparam int unsigned       BIW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIW-1:0]    LAST_IDX = BIW'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam int unsigned       TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) + 1 : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, ERROR} state_t;

  state_t            state_q;
  logic [BIW-1:0]    byte_idx_q;
  logic [TW-1:0]     timer_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_ins;
  logic [BIW-1:0]    lane;

  // Current assembly buffer with the incoming byte dropped into its lane.
  always_comb begin
    lane    = BIG_ENDIAN ? (LAST_IDX - byte_idx_q) : byte_idx_q;
    asm_ins = asm_q;
    asm_ins[{lane, 3'b000} +: 8] = rx_byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      asm_q       <= '0;
      we_o        <= 1'b0;
      addr_o      <= BASE_ADDR;
      wdata_o     <= '0;
      core_rst_no <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      word_cnt_o  <= '0;
    end else if (prog_i) begin
      state_q     <= COLLECT;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      we_o        <= 1'b0;
      addr_o      <= BASE_ADDR;
      core_rst_no <= 1'b0;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      word_cnt_o  <= '0;
    end else begin
      we_o   <= 1'b0;
      done_o <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (rx_dv_i) begin
            asm_q   <= asm_ins;
            timer_q <= '0;
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_q <= '0;
              wdata_o    <= asm_ins;
              if (asm_ins == EOP_WORD) begin
                state_q     <= IDLE;
                core_rst_no <= 1'b1;
                done_o      <= 1'b1;
                busy_o      <= 1'b0;
              end else begin
                state_q <= WRITE;
                we_o    <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + BIW'(1);
            end
          end else if (TIMEOUT_CYC != 0 && byte_idx_q != '0) begin
            // A stalled sender loses the partial word rather than corrupting the next one.
            if (timer_q == TMO_LAST) begin
              byte_idx_q <= '0;
              timer_q    <= '0;
              err_o      <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        WRITE: begin
          word_cnt_o <= word_cnt_o + 1'b1;
          timer_q    <= '0;
          if (addr_o == ADDR_MAX) begin
            state_q <= ERROR;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            addr_o  <= addr_o + 1'b1;
            state_q <= COLLECT;
            if (rx_dv_i) begin
              asm_q      <= asm_ins;
              byte_idx_q <= BIW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
